// File: rtl/rxe_ipv4_hdrchk.sv
// Receive-path IPv4 header checker.
// Assembles bytes from a nibble or byte stream and can skip one 802.1Q tag.
// It identifies IPv4, checks IHL and the ones-complement header checksum,
// then pulses a done strobe and keeps a saturating count of flagged packets.
//
// Packet tracking (no explicit state enum; the flags below act as the FSM):
//   state        | meaning
//   wait_idle    | after reset or cancel, ignore beats until i_v is low
//   parsing      | counting bytes, capturing EtherType, waiting for byte H
//   active       | IPv4 confirmed, summing header words up to byte H+L-1
//   done/ignored | verdict given or packet not IPv4; hold until packet end
module rxe_ipv4_hdrchk #(
    parameter int DW       = 4,
    parameter bit OPT_VLAN = 1'b1,
    parameter int CNTW     = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ce,
    input  logic            i_en,
    input  logic            i_cancel,
    input  logic            i_v,
    input  logic [DW-1:0]   i_d,
    output logic            o_err,
    output logic            o_ipv4,
    output logic            o_hdr_done,
    output logic [CNTW-1:0] o_err_count
);

    logic        wait_idle;
    logic        beat_ok;
    logic        byte_stb;
    logic [7:0]  cur_byte;
    logic [10:0] byte_idx;
    logic [15:0] etype;
    logic        vlan;
    logic        active;
    logic [10:0] hdr_end;
    logic [7:0]  word_hi;
    logic [15:0] acc;
    logic [10:0] hdr_start;
    logic [16:0] sum17;
    logic [15:0] acc_next;
    logic        cnt_max;

    assign beat_ok = i_ce && i_v && !i_cancel && !wait_idle;

    generate
        if (DW == 8) begin : g_byte
            assign byte_stb = beat_ok;
            assign cur_byte = i_d;
        end else begin : g_nib
            logic [3:0] nib_lo;
            logic       nib_phase;

            // Hold the first (low) nibble and track which half of the byte is due.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    nib_lo    <= 4'd0;
                    nib_phase <= 1'b0;
                end else if (i_ce) begin
                    if (!beat_ok) begin
                        nib_phase <= 1'b0;
                    end else begin
                        if (!nib_phase) nib_lo <= i_d;
                        nib_phase <= ~nib_phase;
                    end
                end
            end

            assign byte_stb = beat_ok && nib_phase;
            assign cur_byte = {i_d, nib_lo};
        end
    endgenerate

    assign hdr_start = vlan ? 11'd18 : 11'd14;
    assign sum17     = {1'b0, acc} + {1'b0, word_hi, cur_byte};
    assign acc_next  = sum17[15:0] + {15'd0, sum17[16]};
    assign cnt_max   = &o_err_count;

    // Byte counting, EtherType/VLAN capture, IHL check, checksum and verdict.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wait_idle   <= 1'b1;
            byte_idx    <= 11'd0;
            etype       <= 16'd0;
            vlan        <= 1'b0;
            active      <= 1'b0;
            hdr_end     <= 11'd0;
            word_hi     <= 8'd0;
            acc         <= 16'd0;
            o_err       <= 1'b0;
            o_ipv4      <= 1'b0;
            o_hdr_done  <= 1'b0;
            o_err_count <= '0;
        end else begin
            o_hdr_done <= 1'b0;
            if (i_ce) begin
                if (!i_v || i_cancel) begin
                    // A cancelled packet keeps being ignored until i_v drops.
                    wait_idle <= i_v;
                    byte_idx  <= 11'd0;
                    etype     <= 16'd0;
                    vlan      <= 1'b0;
                    active    <= 1'b0;
                    acc       <= 16'd0;
                    o_err     <= 1'b0;
                    o_ipv4    <= 1'b0;
                end else if (byte_stb) begin
                    if (byte_idx != 11'd2047) byte_idx <= byte_idx + 11'd1;
                    if (byte_idx == 11'd12) etype[15:8] <= cur_byte;
                    if (byte_idx == 11'd13) etype[7:0]  <= cur_byte;
                    if (OPT_VLAN && byte_idx == 11'd13 &&
                        etype[15:8] == 8'h81 && cur_byte == 8'h00) vlan <= 1'b1;
                    if (vlan && byte_idx == 11'd16) etype[15:8] <= cur_byte;
                    if (vlan && byte_idx == 11'd17) etype[7:0]  <= cur_byte;

                    if (byte_idx == hdr_start) begin
                        if (etype == 16'h0800 && cur_byte[7:4] == 4'h4) begin
                            o_ipv4 <= 1'b1;
                            if (cur_byte[3:0] < 4'd5) begin
                                o_hdr_done <= 1'b1;
                                o_err      <= i_en;
                                if (i_en && !o_err && !cnt_max)
                                    o_err_count <= o_err_count + {{(CNTW-1){1'b0}}, 1'b1};
                            end else begin
                                active  <= 1'b1;
                                hdr_end <= hdr_start + {5'd0, cur_byte[3:0], 2'b00} - 11'd1;
                                word_hi <= cur_byte;
                                acc     <= 16'd0;
                            end
                        end
                    end else if (active) begin
                        if (!byte_idx[0]) begin
                            word_hi <= cur_byte;
                        end else begin
                            acc <= acc_next;
                            if (byte_idx == hdr_end) begin
                                active     <= 1'b0;
                                o_hdr_done <= 1'b1;
                                o_err      <= i_en && (acc_next != 16'hFFFF);
                                if (i_en && (acc_next != 16'hFFFF) && !o_err && !cnt_max)
                                    o_err_count <= o_err_count + {{(CNTW-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rxe_ipv4_hdrchk.sv
// Bench for rxe_ipv4_hdrchk: byte-stream, nibble-stream and 2-bit-counter
// instances, with a byte-level reference model feeding a verdict scoreboard.
module tb_rxe_ipv4_hdrchk;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ce8, v8, cancel8;
    logic [7:0] d8;
    logic       ce4, v4, cancel4;
    logic [3:0] d4;

    logic        err8, ipv48, done8;
    logic [15:0] cnt8;
    logic        err2, ipv42, done2;
    logic [1:0]  cnt2;
    logic        err4, ipv44, done4;
    logic [15:0] cnt4;

    rxe_ipv4_hdrchk #(.DW(8), .OPT_VLAN(1), .CNTW(16)) dut8 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce8), .i_en(en), .i_cancel(cancel8),
        .i_v(v8), .i_d(d8), .o_err(err8), .o_ipv4(ipv48), .o_hdr_done(done8),
        .o_err_count(cnt8));

    rxe_ipv4_hdrchk #(.DW(8), .OPT_VLAN(1), .CNTW(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce8), .i_en(en), .i_cancel(cancel8),
        .i_v(v8), .i_d(d8), .o_err(err2), .o_ipv4(ipv42), .o_hdr_done(done2),
        .o_err_count(cnt2));

    rxe_ipv4_hdrchk #(.DW(4), .OPT_VLAN(1), .CNTW(16)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce4), .i_en(en), .i_cancel(cancel4),
        .i_v(v4), .i_d(d4), .o_err(err4), .o_ipv4(ipv44), .o_hdr_done(done4),
        .o_err_count(cnt4));

    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        logic err;
    } exp_t;

    exp_t       q[$];
    int         checks;
    int         failures;
    logic [7:0] pkt [0:127];
    int         plen;
    logic [7:0] base_hdr [0:19];
    int         exp_h;
    int         exp_stop;
    logic       cur_err;
    int         exp_cnt16;
    int         exp_cnt2;
    int         exp_cnt4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int sel, input int idx, input logic e);
        exp_t x;
        x.idx = idx;
        x.err = e;
        q.push_back(x);
        if (e) begin
            if (sel == 0) begin
                exp_cnt16++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end else begin
                exp_cnt4++;
            end
        end
    endtask

    // Reference verdict for the first n bytes of pkt.
    task automatic model(input int sel, input int n, input logic en_v);
        logic [15:0] e;
        logic [15:0] s;
        logic [16:0] t;
        int          off, h, ihl, l;
        exp_h    = -1;
        exp_stop = n;
        cur_err  = 1'b0;
        if (n < 14) return;
        e   = {pkt[12], pkt[13]};
        off = 0;
        if (e == 16'h8100) begin
            off = 4;
            if (n < 18) return;
            e = {pkt[16], pkt[17]};
        end
        h = 14 + off;
        if (n <= h || e != 16'h0800 || pkt[h][7:4] != 4'h4) return;
        exp_h = h;
        ihl   = int'(pkt[h][3:0]);
        if (ihl < 5) begin
            push(sel, h, en_v);
            return;
        end
        l = 4 * ihl;
        if (n < h + l) return;
        s = 16'd0;
        for (int k = 0; k < l; k += 2) begin
            t = {1'b0, s} + {1'b0, pkt[h+k], pkt[h+k+1]};
            s = t[15:0] + {15'd0, t[16]};
        end
        push(sel, h + l - 1, en_v && (s != 16'hFFFF));
    endtask

    task automatic make_pkt(input int vlan, input logic [15:0] et, input logic [7:0] b0,
                            input int fix);
        int          off, h, l;
        logic [15:0] s;
        logic [16:0] t;
        off = vlan ? 4 : 0;
        h   = 14 + off;
        for (int i = 0; i < 12; i++) pkt[i] = 8'h10 + 8'(i);
        if (vlan != 0) begin
            pkt[12] = 8'h81; pkt[13] = 8'h00; pkt[14] = 8'h00; pkt[15] = 8'h05;
        end
        pkt[12+off] = et[15:8];
        pkt[13+off] = et[7:0];
        l = (b0[3:0] >= 4'd5) ? 4 * int'(b0[3:0]) : 20;
        for (int i = 0; i < l; i++) pkt[h+i] = (i < 20) ? base_hdr[i] : 8'h00;
        pkt[h] = b0;
        if (fix != 0) begin
            pkt[h+10] = 8'h00;
            pkt[h+11] = 8'h00;
            s = 16'd0;
            for (int k = 0; k < l; k += 2) begin
                t = {1'b0, s} + {1'b0, pkt[h+k], pkt[h+k+1]};
                s = t[15:0] + {15'd0, t[16]};
            end
            pkt[h+10] = ~s[15:8];
            pkt[h+11] = ~s[7:0];
        end
        plen = h + l;
    endtask

    task automatic check_byte(input int sel, input int i);
        logic od, oe, oi;
        exp_t x;
        if (sel == 0) begin od = done8; oe = err8; oi = ipv48; end
        else          begin od = done4; oe = err4; oi = ipv44; end
        if (q.size() > 0 && q[0].idx == i) begin
            x = q.pop_front();
            chk($sformatf("done_at_byte%0d", i), {31'd0, od}, 32'd1);
            chk($sformatf("err_at_done%0d", i), {31'd0, oe}, {31'd0, x.err});
            cur_err = x.err;
        end else begin
            chk($sformatf("no_done_byte%0d", i), {31'd0, od}, 32'd0);
            chk($sformatf("err_byte%0d", i), {31'd0, oe}, {31'd0, cur_err && (i < exp_stop)});
        end
        chk($sformatf("ipv4_byte%0d", i), {31'd0, oi},
            {31'd0, (exp_h >= 0) && (i >= exp_h) && (i < exp_stop)});
    endtask

    task automatic check_end(input int sel);
        if (sel == 0) begin
            chk("end_done8", {31'd0, done8}, 32'd0);
            chk("end_err8", {31'd0, err8}, 32'd0);
            chk("end_ipv48", {31'd0, ipv48}, 32'd0);
            chk("count16", {16'd0, cnt8}, exp_cnt16);
            chk("count2", {30'd0, cnt2}, exp_cnt2);
        end else begin
            chk("end_done4", {31'd0, done4}, 32'd0);
            chk("end_err4", {31'd0, err4}, 32'd0);
            chk("end_ipv44", {31'd0, ipv44}, 32'd0);
            chk("count4", {16'd0, cnt4}, exp_cnt4);
        end
        chk("scoreboard_empty", q.size(), 32'd0);
        q.delete();
    endtask

    task automatic send8(input logic en_v);
        model(0, plen, en_v);
        @(negedge clk); en = en_v; ce8 = 1'b1; v8 = 1'b0;
        for (int i = 0; i < plen; i++) begin
            @(negedge clk); v8 = 1'b1; d8 = pkt[i];
            @(posedge clk); #1;
            check_byte(0, i);
        end
        @(negedge clk); v8 = 1'b0; d8 = 8'h00;
        @(posedge clk); #1;
        check_end(0);
        @(negedge clk); ce8 = 1'b0;
    endtask

    // Nibble stream with an i_ce=0 beat (carrying junk) between every pair.
    task automatic send4(input logic en_v, input int cancel_at, input int reset_at);
        int stop;
        stop = plen;
        if (cancel_at >= 0) stop = cancel_at;
        if (reset_at >= 0) stop = reset_at;
        model(1, stop, en_v);
        @(negedge clk); en = en_v; ce4 = 1'b1; v4 = 1'b0;
        for (int i = 0; i < plen; i++) begin
            @(negedge clk); ce4 = 1'b1; v4 = 1'b1; d4 = pkt[i][3:0];
            cancel4 = (i == cancel_at);
            rst     = (i == reset_at);
            @(posedge clk); #1;
            chk("no_done_lo_nib", {31'd0, done4}, 32'd0);
            if (i == reset_at) begin
                exp_cnt16 = 0; exp_cnt2 = 0; exp_cnt4 = 0;
                chk("reset_err4", {31'd0, err4}, 32'd0);
                chk("reset_cnt8", {16'd0, cnt8}, 32'd0);
            end
            @(negedge clk); ce4 = 1'b0; v4 = 1'b0; cancel4 = 1'b1; rst = 1'b0;
            d4 = 4'($urandom);
            @(posedge clk); #1;
            chk("no_done_gap", {31'd0, done4}, 32'd0);
            @(negedge clk); ce4 = 1'b1; v4 = 1'b1; cancel4 = 1'b0; d4 = pkt[i][7:4];
            @(posedge clk); #1;
            check_byte(1, i);
        end
        @(negedge clk); v4 = 1'b0; d4 = 4'h0;
        @(posedge clk); #1;
        check_end(1);
        @(negedge clk); ce4 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_cnt16 = 0; exp_cnt2 = 0; exp_cnt4 = 0;
        chk("rst_err8", {31'd0, err8}, 32'd0);
        chk("rst_ipv48", {31'd0, ipv48}, 32'd0);
        chk("rst_done8", {31'd0, done8}, 32'd0);
        chk("rst_cnt8", {16'd0, cnt8}, 32'd0);
        chk("rst_err2", {31'd0, err2}, 32'd0);
        chk("rst_cnt2", {30'd0, cnt2}, 32'd0);
        chk("rst_err4", {31'd0, err4}, 32'd0);
        chk("rst_ipv44", {31'd0, ipv44}, 32'd0);
        chk("rst_done4", {31'd0, done4}, 32'd0);
        chk("rst_cnt4", {16'd0, cnt4}, 32'd0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; en = 1'b0;
        ce8 = 1'b0; v8 = 1'b0; cancel8 = 1'b0; d8 = 8'h00;
        ce4 = 1'b0; v4 = 1'b0; cancel4 = 1'b0; d4 = 4'h0;
        checks = 0; failures = 0;
        exp_cnt16 = 0; exp_cnt2 = 0; exp_cnt4 = 0;
        base_hdr = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                     8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
        repeat (3) @(posedge clk);
        do_reset();

        // Good header, then bad checksum with and without reporting enabled.
        make_pkt(0, 16'h0800, 8'h45, 0); send8(1'b1);
        make_pkt(0, 16'h0800, 8'h45, 0); pkt[25] = 8'h62; send8(1'b1);
        make_pkt(0, 16'h0800, 8'h45, 0); pkt[25] = 8'h62; send8(1'b0);

        // Non-IPv4 with garbage header; VLAN-tagged good header.
        make_pkt(0, 16'h0806, 8'h45, 0); pkt[20] = pkt[20] ^ 8'hFF; send8(1'b1);
        make_pkt(1, 16'h0800, 8'h45, 0); send8(1'b1);

        // IHL below 5, then IHL=6 with a valid sum; short packet cut before the end.
        make_pkt(0, 16'h0800, 8'h44, 0); send8(1'b1);
        make_pkt(0, 16'h0800, 8'h46, 1); send8(1'b1);
        make_pkt(0, 16'h0800, 8'h45, 0); pkt[25] = 8'h62; plen = 30; send8(1'b1);

        // Saturation of the 2-bit counter from a clean start.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            make_pkt(0, 16'h0800, 8'h45, 0); pkt[25] = 8'h62; send8(1'b1);
        end

        // Nibble stream: good, bad, cancel, mid-packet reset, recovery.
        make_pkt(0, 16'h0800, 8'h45, 0); send4(1'b1, -1, -1);
        make_pkt(1, 16'h0800, 8'h45, 0); pkt[29] = 8'h62; send4(1'b1, -1, -1);
        make_pkt(0, 16'h0800, 8'h45, 0); send4(1'b1, 20, -1);
        make_pkt(0, 16'h0800, 8'h45, 0); pkt[25] = 8'h62; send4(1'b1, -1, 25);
        make_pkt(0, 16'h0800, 8'h45, 0); pkt[25] = 8'h62; send4(1'b1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rxe_ipv4_hdrchk.md
Name: rxe_ipv4_hdrchk

Overview:
Parametrised next-generation receive-path IPv4 header checker for the Ethernet RX chain. It sits after preamble/CRC handling and before the RX packet buffer. It accepts nibble or byte streams and can optionally skip one 802.1Q VLAN tag. It validates IHL and the ones-complement header checksum, reports the header verdict with a done strobe, and keeps a saturating count of flagged packets.

Parameters:
DW, 4, data width per i_ce beat; 4 = nibble stream (low nibble of each byte first), 8 = byte stream; other values illegal
OPT_VLAN, 1, when 1, EtherType 0x8100 at bytes 12-13 shifts the EtherType field and the IP header by 4 bytes
CNTW, 16, width of the saturating error counter

Ports:
i_clk  in  1  system clock
i_reset  in  1  reset; synchronous, active-high
i_ce  in  1  beat qualifier; all other inputs are ignored when low
i_en  in  1  error-reporting enable, sampled at header evaluation
i_cancel  in  1  abort current packet (on an i_ce beat)
i_v  in  1  valid; a packet is a contiguous run of i_v=1 beats
i_d  in  DW  data nibble or byte
o_err  out  1  header failed (bad IHL or bad checksum), held until packet end
o_ipv4  out  1  current packet identified as IPv4
o_hdr_done  out  1  one-clock pulse when header evaluation completes
o_err_count  out  CNTW  count of packets flagged with o_err, saturating

Behaviour:
- Reset values: o_err=0, o_ipv4=0, o_hdr_done=0, o_err_count=0. All internal state is idle.
- All outputs are registered. State advances only on i_clk edges with i_ce=1. o_hdr_done is forced to 0 on every edge except the evaluating one, including i_ce=0 edges.
- End of packet (i_ce=1 and i_v=0), or i_cancel=1 on an i_ce beat: the next edge clears the byte counter, accumulator, o_err and o_ipv4. Cancel has priority over data on the same beat.
- Byte assembly: DW=8 gives one byte per beat. DW=4 assembles a byte from two beats, {second,first}; a byte "completes" on its second beat.
- Byte index B counts from 0 and saturates at 2047 (11 bits). It holds there with no wrap.
- EtherType E = bytes 12-13, big-endian.
- If OPT_VLAN and E==0x8100, the offset is 4 and E is re-read from bytes 16-17. Otherwise the offset is 0.
- IP header starts at H = 14 + offset.
- Byte H: IPv4 requires E==0x0800 and the high nibble = 4. When true, o_ipv4 sets on the edge completing byte H. Otherwise the packet is ignored until its end: no done, no err.
- IHL = low nibble of byte H.
  - If IHL<5: evaluation happens immediately at byte H. o_hdr_done pulses and o_err <= i_en.
  - Otherwise header length L = 4*IHL bytes (20..60).
- Checksum: big-endian 16-bit words over bytes H..H+L-1 are summed in 17-bit ones-complement with end-around carry folded each add. Pass iff the final folded sum == 0xFFFF.
- Evaluation on the edge completing byte H+L-1:
  - o_hdr_done=1 for exactly that clock.
  - o_err <= i_en && fail.
- o_err stays set until end of packet, cancel, or reset.
- Packet ending before H+L-1 completes: no done, no error, counter unchanged.
- o_err_count increments by 1 on each edge where o_err goes 0->1. It holds at all-ones and is cleared only by i_reset.
- i_reset mid-packet: all state returns to idle. Subsequent beats of that packet are ignored until i_v has been low for one i_ce beat.

Test Plan:
1. DW=8, OPT_VLAN=1, EtherType 08 00, header 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7 -> o_ipv4=1 after byte 14; o_hdr_done pulses once after byte 33; o_err=0; count=0.
2. Same with byte 25 = 62 (checksum B862), i_en=1 -> o_err=1 from byte 33 edge until i_v drops; count=1. Repeat with i_en=0 -> o_err=0, count=1 unchanged.
3. EtherType 08 06 with a corrupt "header" -> o_ipv4=0, no o_hdr_done, o_err=0. Then VLAN 81 00 00 05 08 00 + test-1 header -> o_hdr_done after byte 37, o_err=0.
4. Byte 14 = 0x44 (IHL=4), i_en=1 -> o_hdr_done and o_err=1 on byte 14 edge. Byte 14 = 0x46 with a 24-byte header and valid sum -> done after byte 37, o_err=0.
5. DW=4, test-1 packet as nibbles with i_ce toggling 1/0 -> identical verdict and done timing relative to completed bytes. i_cancel at byte 20 -> no done, o_ipv4 clears. i_reset at byte 25 -> all outputs 0 and the packet is ignored.
6. CNTW=2, four bad packets -> count 1, 2, 3, 3 (saturates).
